// File: rtl/bird_column.sv
// Column-wide bird position controller for the Floppy Bird LED display.
// Tracks the bird row, applies flap lift and divided gravity, and flags floor/pipe crashes.
module bird_column #(
    parameter int ROWS      = 8,
    parameter int START_ROW = 4,
    parameter int FLAP_ROWS = 1,
    parameter int FALL_DIV  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic                     flap_i,
    input  logic                     gravity_tick_i,
    input  logic [ROWS-1:0]          pipe_mask_i,
    output logic [ROWS-1:0]          rows_out_o,
    output logic [$clog2(ROWS)-1:0]  pos_o,
    output logic                     alive_o,
    output logic                     crash_o
);

    localparam int PW = $clog2(ROWS);
    localparam int FW = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FLY  = 2'd1,
        S_DEAD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            flap_q;
    logic [ROWS-1:0] rows_out_q, rows_out_d;
    logic            alive_q, alive_d;
    logic            crash_q, crash_d;

    logic            flap_edge_s;
    logic            fall_due_s;
    logic            pipe_hit_s;
    logic [PW:0]     flap_sum_s;
    logic [PW-1:0]   flap_pos_s;

    function automatic logic [ROWS-1:0] onehot(input logic [PW-1:0] p);
        onehot = {{(ROWS-1){1'b0}}, 1'b1} << p;
    endfunction

    assign flap_edge_s = flap_i & ~flap_q;
    assign fall_due_s  = gravity_tick_i && (fcnt_q == FW'(FALL_DIV - 1));
    assign pipe_hit_s  = pipe_mask_i[pos_q];

    // Flap lift computed one bit wider so the ceiling clamp sees the carry.
    always_comb begin
        flap_sum_s = {1'b0, pos_q} + (PW+1)'(FLAP_ROWS);
        if (flap_sum_s > (PW+1)'(ROWS - 1)) begin
            flap_pos_s = PW'(ROWS - 1);
        end else begin
            flap_pos_s = flap_sum_s[PW-1:0];
        end
    end

    // State, position, fall counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pos_q      <= PW'(START_ROW);
            fcnt_q     <= {FW{1'b0}};
            flap_q     <= 1'b0;
            rows_out_q <= onehot(PW'(START_ROW));
            alive_q    <= 1'b0;
            crash_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            fcnt_q     <= fcnt_d;
            flap_q     <= flap_i;
            rows_out_q <= rows_out_d;
            alive_q    <= alive_d;
            crash_q    <= crash_d;
        end
    end

    // Next-state and datapath; FLY applies pipe > flap > gravity priority.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            S_IDLE: begin
                pos_d  = PW'(START_ROW);
                fcnt_d = {FW{1'b0}};
                if (start_i) begin
                    state_d = S_FLY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLY: begin
                if (pipe_hit_s) begin
                    state_d = S_DEAD;
                end else if (flap_edge_s) begin
                    pos_d  = flap_pos_s;
                    fcnt_d = {FW{1'b0}};
                end else if (fall_due_s) begin
                    if (pos_q == {PW{1'b0}}) begin
                        state_d = S_DEAD;
                    end else begin
                        pos_d  = pos_q - PW'(1);
                        fcnt_d = {FW{1'b0}};
                    end
                end else if (gravity_tick_i) begin
                    fcnt_d = fcnt_q + FW'(1);
                end else begin
                    state_d = S_FLY;
                end
            end
            S_DEAD: begin
                if (start_i) begin
                    state_d = S_IDLE;
                    pos_d   = PW'(START_ROW);
                    fcnt_d  = {FW{1'b0}};
                end else begin
                    state_d = S_DEAD;
                end
            end
            default: begin
                state_d = S_IDLE;
                pos_d   = PW'(START_ROW);
                fcnt_d  = {FW{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so the registered flags line up with pos.
    always_comb begin
        rows_out_d = onehot(pos_d);
        alive_d    = (state_d == S_FLY);
        crash_d    = (state_d == S_DEAD) && (state_q != S_DEAD);
    end

    assign rows_out_o = rows_out_q;
    assign pos_o      = pos_q;
    assign alive_o    = alive_q;
    assign crash_o    = crash_q;

endmodule
